// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame defaults
// and the baud select codes used by the clock handler.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [1:0] BAUD_9600   = 2'b00;
  localparam logic [1:0] BAUD_19200  = 2'b01;
  localparam logic [1:0] BAUD_38400  = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;

endpackage

// File: rtl/uart_rx_sampler_sync_edge.sv
// sync_edge: two-flop synchronizer plus rising-edge pulse.
// Ports: clk, rst (sync, high), d in; q_sync, rise out.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q_sync,
  output logic rise
);

  logic s1;
  logic s2;

  // Flops reset high so an idle-high line or a
  // high clock level never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q_sync = s2;
  // Edge is taken against the single-registered copy.
  assign rise   = d & ~s1;

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 receiver oversampling rx on ticks from clk_16bd.
// In: clk, rst, clk_16bd, baud_ready, rx.
// Out: data, data_valid, frame_err, busy.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_16bd,
  input  logic                 baud_ready,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int MID = OVERSAMPLE / 2 - 1;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] MID_T  = TW'(MID);
  localparam logic [TW-1:0] LAST_T = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] ONE_T  = TW'(1);
  localparam logic [BW-1:0] LBIT   = BW'(DATA_BITS - 1);

  logic rx_s;
  logic tick;
  logic rx_rise_unused;
  logic clk_sync_unused;

  logic [1:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  sync_edge u_rx_sync (
    .clk    (clk),
    .rst    (rst),
    .d      (rx),
    .q_sync (rx_s),
    .rise   (rx_rise_unused)
  );

  sync_edge u_tick (
    .clk    (clk),
    .rst    (rst),
    .d      (clk_16bd),
    .q_sync (clk_sync_unused),
    .rise   (tick)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    data_valid <= 1'b0;
    frame_err  <= 1'b0;
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data      <= '0;
    end else if (!baud_ready) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= ONE_T;
          end
        end
        START: begin
          if (tick_cnt == MID_T) begin
            // High at mid-start is a glitch.
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            tick_cnt <= tick_cnt + ONE_T;
          end
        end
        DATA: begin
          // Counting restarted at mid-start, so
          // the wrap point is mid-bit.
          tick_cnt <= tick_cnt + ONE_T;
          if (tick_cnt == LAST_T) begin
            shift_reg <= {rx_s,
                          shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + BW'(1);
            if (bit_cnt == LBIT) begin
              state    <= STOP;
              tick_cnt <= '0;
            end
          end
        end
        default: begin
          tick_cnt <= tick_cnt + ONE_T;
          if (tick_cnt == LAST_T) begin
            state    <= IDLE;
            tick_cnt <= '0;
            if (rx_s) begin
              data       <= shift_reg;
              data_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed testbench for uart_rx_sampler.
// Drives clk_16bd and rx on negedges, samples on negedges.
module tb_uart_rx_sampler;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_16bd = 1'b0;
  logic       baud_ready = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_err   = 0;
  int half    = 2;
  logic [1:0] code = BAUD_38400;
  logic [7:0] got[$];

  uart_rx_sampler dut (
    .clk        (clk),
    .rst        (rst),
    .clk_16bd   (clk_16bd),
    .baud_ready (baud_ready),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the clock handler: 38400 -> 4 clk
  // per tick, 19200 -> 8 clk per tick.
  initial begin
    forever begin
      repeat (half) @(negedge clk);
      clk_16bd = ~clk_16bd;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid || frame_err) begin
        total++;
        if (data_valid && frame_err) begin
          bad++;
          $display("FAIL both_pulses valid=%b err=%b",
                   data_valid, frame_err);
        end
      end
      if (data_valid) begin
        n_valid++;
        got.push_back(data);
      end
      if (frame_err) n_err++;
    end
  end

  function automatic int bit_clks();
    return 32 * half;
  endfunction

  task automatic clr();
    n_valid = 0;
    n_err   = 0;
    got.delete();
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop_ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (bit_clks()) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bit_clks()) @(negedge clk);
      if (i == 4) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_mid got=%b want=1", busy);
        end
      end
    end
    rx = stop_ok;
    if (stop_ok) repeat (bit_clks()) @(negedge clk);
    else repeat (bit_clks() * 5 / 8) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx = ~rx;
      total += 4;
      if (data !== 8'h00) begin
        bad++;
        $display("FAIL rst_data got=%h want=00", data);
      end
      if (data_valid !== 1'b0) begin
        bad++;
        $display("FAIL rst_valid got=%b want=0",
                 data_valid);
      end
      if (frame_err !== 1'b0) begin
        bad++;
        $display("FAIL rst_err got=%b want=0", frame_err);
      end
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL rst_busy got=%b want=0", busy);
      end
    end
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_nominal();
    code = BAUD_38400;
    half = 2;
    clr();
    send_frame(8'hA5, 1'b1);
    repeat (bit_clks()) @(negedge clk);
    total += 4;
    if (n_valid !== 1) begin
      bad++;
      $display("FAIL nom_count got=%0d want=1", n_valid);
    end
    if (data !== 8'hA5) begin
      bad++;
      $display("FAIL nom_data got=%h want=a5", data);
    end
    if (n_err !== 0) begin
      bad++;
      $display("FAIL nom_err got=%0d want=0", n_err);
    end
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL nom_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_back_to_back();
    clr();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (bit_clks()) @(negedge clk);
    total++;
    if (got.size() !== 2) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=2",
               got.size());
    end else begin
      total += 2;
      if (got[0] !== 8'h00) begin
        bad++;
        $display("FAIL b2b_first got=%h want=00",
                 got[0]);
      end
      if (got[1] !== 8'hFF) begin
        bad++;
        $display("FAIL b2b_second got=%h want=ff",
                 got[1]);
      end
    end
    total++;
    if (n_err !== 0) begin
      bad++;
      $display("FAIL b2b_err got=%0d want=0", n_err);
    end
  endtask

  task automatic test_glitch();
    clr();
    @(negedge clk);
    rx = 1'b0;
    repeat (4 * 2 * half) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL glitch_start got=%b want=1", busy);
    end
    rx = 1'b1;
    repeat (bit_clks() * 2) @(negedge clk);
    total += 3;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL glitch_busy got=%b want=0", busy);
    end
    if (n_valid !== 0) begin
      bad++;
      $display("FAIL glitch_valid got=%0d want=0",
               n_valid);
    end
    if (n_err !== 0) begin
      bad++;
      $display("FAIL glitch_err got=%0d want=0", n_err);
    end
  endtask

  task automatic test_frame_err();
    clr();
    send_frame(8'h3C, 1'b0);
    repeat (bit_clks() * 2) @(negedge clk);
    total += 4;
    if (n_err !== 1) begin
      bad++;
      $display("FAIL ferr_count got=%0d want=1", n_err);
    end
    if (n_valid !== 0) begin
      bad++;
      $display("FAIL ferr_valid got=%0d want=0", n_valid);
    end
    if (data !== 8'hFF) begin
      bad++;
      $display("FAIL ferr_data got=%h want=ff", data);
    end
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ferr_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_baud_change();
    logic [7:0] b;
    b = 8'h55;
    clr();
    @(negedge clk);
    rx = 1'b0;
    repeat (bit_clks()) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (bit_clks()) @(negedge clk);
    end
    rx = b[3];
    repeat (bit_clks() / 2) @(negedge clk);
    baud_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rx = 1'b1;
    total += 2;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy got=%b want=0", busy);
    end
    if (data !== 8'hFF) begin
      bad++;
      $display("FAIL abort_data got=%h want=ff", data);
    end
    code = BAUD_19200;
    half = 4;
    repeat (40) @(negedge clk);
    baud_ready = 1'b1;
    repeat (bit_clks()) @(negedge clk);
    total += 2;
    if (n_valid !== 0) begin
      bad++;
      $display("FAIL abort_valid got=%0d want=0",
               n_valid);
    end
    if (n_err !== 0) begin
      bad++;
      $display("FAIL abort_err got=%0d want=0", n_err);
    end
    send_frame(8'h81, 1'b1);
    repeat (bit_clks()) @(negedge clk);
    total += 3;
    if (n_valid !== 1) begin
      bad++;
      $display("FAIL new_count got=%0d want=1", n_valid);
    end
    if (data !== 8'h81) begin
      bad++;
      $display("FAIL new_data got=%h want=81", data);
    end
    if (n_err !== 0) begin
      bad++;
      $display("FAIL new_err got=%0d want=0", n_err);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_baud_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Serial receive stage directly downstream of the clock handler.
- Consumes the handler's 16x-baud clock output (clk_16bd) as a sampled level, not as a clock; its rising edges become oversampling ticks.
- Recovers 8N1 frames from the rx line and presents each received byte with a one-cycle valid strobe to the VGA-side consumer.
- Everything runs on the single system clock clk.

Parameters:
- DATA_BITS, 8, payload bits per frame, sent LSB first.
- OVERSAMPLE, 16, ticks per bit period; must be even and at least 4.
- MID, OVERSAMPLE/2-1 (7), tick index within a bit at which the line is sampled.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_16bd  in  1  16x-baud square wave from the clock handler; treated as a level.
- baud_ready  in  1  high when the baud configuration is stable; low aborts reception.
- rx  in  1  asynchronous serial line; idles high.
- data  out  DATA_BITS  last received byte; held until the next valid frame.
- data_valid  out  1  one-clk pulse when data updates.
- frame_err  out  1  one-clk pulse when the stop bit is sampled low.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE, tick and bit counters=0, data=0, data_valid=0, frame_err=0, busy=0. Synchronizer flops and the clk_16bd history flop are set to 1.
- Input conditioning:
  - rx passes through a 2-flop synchronizer to give rx_s.
  - clk_16bd is registered once; tick = clk_16bd & ~clk_16bd_q, a 1-clk pulse per rising edge.
  - All FSM and counter activity below advances only on cycles where tick=1, except aborts and output pulses.
- IDLE: tick_cnt=0. On a tick with rx_s=0, go to START with tick_cnt=1.
- START: tick_cnt increments on each tick. On the tick where tick_cnt==MID:
  - rx_s=1 means a glitch: return to IDLE, no error flagged.
  - rx_s=0: go to DATA with tick_cnt=0 and bit_cnt=0.
- DATA: tick_cnt increments modulo OVERSAMPLE. On the tick where tick_cnt==OVERSAMPLE-1 (the mid-bit point, since counting restarted at mid-start):
  - Shift rx_s into shift_reg MSB; shift_reg shifts right, so byte order is LSB first.
  - bit_cnt increments.
  - When bit_cnt reaches DATA_BITS, go to STOP with tick_cnt=0.
- STOP: on the tick where tick_cnt==OVERSAMPLE-1, sample rx_s.
  - rx_s=1: data<=shift_reg and data_valid pulses on the following clk.
  - rx_s=0: frame_err pulses, data is unchanged.
  - Either way return to IDLE.
- Latency: data_valid asserts 1 clk after the stop-bit sampling tick, i.e. about 9.5 bit periods after the start-bit falling edge.
- data_valid and frame_err are never high in the same cycle and never last longer than 1 clk.
- baud_ready=0:
  - Forces IDLE and clears the counters on the next clk edge, regardless of tick.
  - Suppresses data_valid and frame_err for the aborted frame.
  - data keeps its last value.
  - Reception resumes with the next start edge after baud_ready returns to 1.
- rst has priority over baud_ready, and baud_ready has priority over tick.
- Line held low (break): the frame completes with frame_err=1. The FSM then re-enters START only if rx_s is low on a tick in IDLE, so a continuous break produces one frame_err per frame period.
- Counters saturate nowhere; tick_cnt is $clog2(OVERSAMPLE) bits wide and wraps naturally.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - The OVERSAMPLE and DATA_BITS defaults.
  - The baud select codes shared with the clock handler.
- One natural sub-module: sync_edge. It takes (clk, rst, d) and outputs (q_sync, rise). It is instantiated for rx (q_sync used) and for clk_16bd (rise used as tick).

Test Plan:
- Reset: hold rst=1 for 3 clks with rx toggling -> data=8'h00, data_valid=0, frame_err=0, busy=0 throughout.
- Nominal byte: with the clock handler on baud code 2'b10, drive an 8N1 frame of 8'hA5 -> exactly one data_valid pulse, data=8'hA5, frame_err=0, busy falls after the stop sample.
- Back-to-back frames: send 8'h00 then 8'hFF with no idle gap -> two data_valid pulses in order, with data=8'h00 and then data=8'hFF.
- Glitch rejection: drive rx low for 4 ticks then high -> FSM returns to IDLE, with no data_valid and no frame_err.
- Framing error: send 8'h3C with the stop bit driven 0 -> frame_err pulses once, data keeps its previous value, no data_valid.
- Baud change mid-frame: drop baud_ready during bit 3 of 8'h55, switch to code 2'b01, re-raise baud_ready, send 8'h81 at the new rate -> no output for the aborted frame, then data=8'h81 with one data_valid.
